// File: rtl/box_filter_pkg.sv
// box_filter_pkg: shared sizes and types for the multi-channel box-filter scheduler
package box_filter_pkg;
  localparam int NUM_CH = 4;
  localparam int FILTER_SIZE = 4;
  localparam int DATA_WIDTH = 32;
  localparam int LOG2_FS = $clog2(FILTER_SIZE);
  localparam int CH_W = $clog2(NUM_CH);
  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [DATA_WIDTH+LOG2_FS-1:0] sum_t;
  typedef logic [CH_W-1:0] ch_idx_t;
  typedef logic [LOG2_FS-1:0] wp_t;
  typedef logic [NUM_CH-1:0] ch_vec_t;
endpackage

// File: rtl/box_filter_sched_if.sv
// box_filter_sched_if: per-channel sample request bus plus tagged result output
//   req_valid/req_data/req_ready : one valid/ready pair per channel
//   out_valid/out_ch/out_data/out_ready : shared result port
//   master = producers/consumer side, slave = scheduler side
interface box_filter_sched_if;
  import box_filter_pkg::*;
  ch_vec_t req_valid;
  ch_vec_t req_ready;
  data_t [NUM_CH-1:0] req_data;
  logic out_valid;
  logic out_ready;
  ch_idx_t out_ch;
  data_t out_data;
  modport master(output req_valid, req_data, out_ready, input req_ready, out_valid, out_ch, out_data);
  modport slave(input req_valid, req_data, out_ready, output req_ready, out_valid, out_ch, out_data);
endinterface

// File: rtl/box_filter_sched_arb.sv
// box_filter_sched_arb: combinational grant pick among requesting channels
//   ptr     : last granted channel (round-robin build only)
//   req     : per-channel request vector
//   gnt_oh  : one-hot grant, zero when nothing requests
//   gnt_idx : index of the granted channel
//   gnt_any : some channel is granted
//   BOX_FILTER_SCHED_RR_EN selects round-robin; otherwise lowest index wins
module box_filter_sched_arb import box_filter_pkg::*; (
`ifdef BOX_FILTER_SCHED_RR_EN
  input  ch_idx_t ptr,
`endif
  input  ch_vec_t req,
  output ch_vec_t gnt_oh,
  output ch_idx_t gnt_idx,
  output logic    gnt_any
);
  ch_idx_t cand [NUM_CH];
  for (genvar i = 0; i < NUM_CH; i++) begin : g_cand
`ifdef BOX_FILTER_SCHED_RR_EN
    assign cand[i] = ch_idx_t'((int'(ptr) + i + 1) % NUM_CH);
`else
    assign cand[i] = ch_idx_t'(i);
`endif
  end
  // scan from lowest priority to highest so the last hit is the winner
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = NUM_CH - 1; k >= 0; k--)
      if (req[cand[k]]) begin
        gnt_idx = cand[k];
        gnt_any = 1'b1;
      end
  end
  assign gnt_oh = gnt_any ? ch_vec_t'(1) << gnt_idx : '0;
endmodule

// File: rtl/box_filter_sched.sv
// box_filter_sched: one shared box-filter datapath time-multiplexed over NUM_CH streams
//   clk, rst : clock and synchronous active-high reset
//   clear    : flush all channel histories, sums and write pointers
//   bus      : box_filter_sched_if.slave (per-channel requests, tagged result port)
//   BOX_FILTER_SCHED_RR_EN selects round-robin arbitration, else fixed priority
module box_filter_sched import box_filter_pkg::*; (
  input logic clk,
  input logic rst,
  input logic clear,
  box_filter_sched_if.slave bus
);
  data_t hist [NUM_CH][FILTER_SIZE];
  sum_t sum [NUM_CH];
  wp_t wp [NUM_CH];
  ch_vec_t gnt_oh;
  ch_idx_t gnt_idx;
  logic gnt_any, go, acc;
  sum_t new_sum;
`ifdef BOX_FILTER_SCHED_RR_EN
  ch_idx_t ptr;
  always_ff @(posedge clk)
    if (rst) ptr <= ch_idx_t'(NUM_CH - 1);
    else if (acc) ptr <= gnt_idx;
`endif
  box_filter_sched_arb u_arb (
`ifdef BOX_FILTER_SCHED_RR_EN
    .ptr(ptr),
`endif
    .req(bus.req_valid),
    .gnt_oh(gnt_oh),
    .gnt_idx(gnt_idx),
    .gnt_any(gnt_any)
  );
  assign go = (!bus.out_valid || bus.out_ready) && !clear && !rst;
  assign bus.req_ready = go ? gnt_oh : '0;
  assign acc = go && gnt_any;
  // the oldest sample leaves the window as the new one enters
  assign new_sum = sum[gnt_idx] - sum_t'(hist[gnt_idx][wp[gnt_idx]]) + sum_t'(bus.req_data[gnt_idx]);
  always_ff @(posedge clk)
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_ch <= '0;
      bus.out_data <= '0;
    end else if (acc) begin
      bus.out_valid <= 1'b1;
      bus.out_ch <= gnt_idx;
      bus.out_data <= data_t'(new_sum >> LOG2_FS);
    end else if (bus.out_ready) bus.out_valid <= 1'b0;
  always_ff @(posedge clk)
    if (rst || clear) begin
      hist <= '{default: '0};
      sum <= '{default: '0};
      wp <= '{default: '0};
    end else if (acc) begin
      hist[gnt_idx][wp[gnt_idx]] <= bus.req_data[gnt_idx];
      sum[gnt_idx] <= new_sum;
      wp[gnt_idx] <= wp[gnt_idx] + wp_t'(1);
    end
endmodule

// File: tb/tb_box_filter_sched.sv
// tb_box_filter_sched: directed and random checks of box_filter_sched against a window-queue model
module tb_box_filter_sched;
  import box_filter_pkg::*;
  logic clk, rst, clear;
  int checks = 0, fails = 0;
  box_filter_sched_if bus();
  box_filter_sched dut (.clk(clk), .rst(rst), .clear(clear), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  longint win [NUM_CH][$];
  logic m_valid;
  int m_ch, m_acc;
  data_t m_data;
`ifdef BOX_FILTER_SCHED_RR_EN
  int m_ptr;
`endif
  function automatic int pick();
    for (int k = 0; k < NUM_CH; k++) begin
`ifdef BOX_FILTER_SCHED_RR_EN
      int c = (m_ptr + 1 + k) % NUM_CH;
`else
      int c = k;
`endif
      if (bus.req_valid[c]) return c;
    end
    return -1;
  endfunction
  function automatic ch_vec_t exp_ready();
    int g = pick();
    if (rst || clear || (m_valid && !bus.out_ready) || g < 0) return '0;
    return ch_vec_t'(1) << g;
  endfunction
  task automatic zero_windows();
    for (int c = 0; c < NUM_CH; c++) begin
      win[c].delete();
      repeat (FILTER_SIZE) win[c].push_back(0);
    end
  endtask
  task automatic model_edge();
    int g = pick();
    longint s = 0;
    m_acc = -1;
    if (rst) begin
      m_valid = 1'b0; m_ch = 0; m_data = '0;
`ifdef BOX_FILTER_SCHED_RR_EN
      m_ptr = NUM_CH - 1;
`endif
      zero_windows();
    end else begin
      if (g >= 0 && !clear && (!m_valid || bus.out_ready)) begin
        void'(win[g].pop_front());
        win[g].push_back(longint'(bus.req_data[g]));
        for (int k = 0; k < win[g].size(); k++) s += win[g][k];
        m_valid = 1'b1; m_ch = g; m_data = data_t'(s / FILTER_SIZE); m_acc = g;
`ifdef BOX_FILTER_SCHED_RR_EN
        m_ptr = g;
`endif
      end else if (bus.out_ready) m_valid = 1'b0;
      if (clear) zero_windows();
    end
  endtask
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask
  task automatic apply_reset();
    rst = 1'b1; clear = 1'b0; bus.req_valid = '0;
    tick();
    rst = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1; clear = 1'b1; bus.req_valid = '1; bus.out_ready = 1'b1;
    for (int c = 0; c < NUM_CH; c++) bus.req_data[c] = data_t'(7);
    tick(); tick();
    checks++; if (bus.req_ready !== '0) begin fails++; $display("FAIL reset_ready: got %b want 0", bus.req_ready); end
    checks++; if (bus.out_valid !== 1'b0 || bus.out_ch !== '0 || bus.out_data !== '0) begin fails++; $display("FAIL reset_out: got v=%b ch=%0d d=%0d want 0/0/0", bus.out_valid, bus.out_ch, bus.out_data); end
    rst = 1'b0; clear = 1'b0; bus.req_valid = '0;
  endtask
  task automatic test_single();
    int d[5] = '{4, 8, 12, 16, 20};
    int e[5] = '{1, 3, 6, 10, 14};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.req_valid = ch_vec_t'(1); bus.req_data[0] = data_t'(d[i]);
      #1;
      checks++; if (bus.req_ready !== ch_vec_t'(1)) begin fails++; $display("FAIL single_ready[%0d]: got %b want 0001", i, bus.req_ready); end
      tick();
      checks++; if (bus.out_valid !== 1'b1 || bus.out_ch !== '0 || bus.out_data !== data_t'(e[i])) begin fails++; $display("FAIL single_out[%0d]: got v=%b ch=%0d d=%0d want 1/0/%0d", i, bus.out_valid, bus.out_ch, bus.out_data, e[i]); end
    end
    bus.req_valid = '0;
  endtask
  task automatic test_isolation();
    int ch[7] = '{1, 2, 1, 2, 1, 1, 0};
    int d[7] = '{100, 8, 100, 8, 100, 100, 24};
    int e[7] = '{25, 2, 50, 4, 75, 100, 18};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus.req_valid = ch_vec_t'(1) << ch[i]; bus.req_data[ch[i]] = data_t'(d[i]);
      #1;
      checks++; if (bus.req_ready !== ch_vec_t'(1) << ch[i]) begin fails++; $display("FAIL iso_ready[%0d]: got %b want ch%0d", i, bus.req_ready, ch[i]); end
      tick();
      checks++; if (bus.out_valid !== 1'b1 || bus.out_ch !== ch_idx_t'(ch[i]) || bus.out_data !== data_t'(e[i])) begin fails++; $display("FAIL iso_out[%0d]: got v=%b ch=%0d d=%0d want 1/%0d/%0d", i, bus.out_valid, bus.out_ch, bus.out_data, ch[i], e[i]); end
    end
    bus.req_valid = '0;
  endtask
  task automatic test_arbitration();
    int g;
    apply_reset();
    bus.out_ready = 1'b1; bus.req_valid = '1;
    for (int c = 0; c < NUM_CH; c++) bus.req_data[c] = data_t'($urandom_range(0, 1000));
    for (int i = 0; i < 2 * NUM_CH; i++) begin
`ifdef BOX_FILTER_SCHED_RR_EN
      g = i % NUM_CH;
`else
      g = 0;
`endif
      #1;
      checks++; if (bus.req_ready !== ch_vec_t'(1) << g) begin fails++; $display("FAIL arb_grant[%0d]: got %b want ch%0d", i, bus.req_ready, g); end
      tick();
      checks++; if (bus.out_ch !== ch_idx_t'(g) || bus.out_data !== m_data) begin fails++; $display("FAIL arb_out[%0d]: got ch=%0d d=%0d want %0d/%0d", i, bus.out_ch, bus.out_data, g, m_data); end
    end
    bus.req_valid = '0;
  endtask
  task automatic test_backpressure();
    data_t hd;
    int hc;
    bus.req_valid = '1; bus.out_ready = 1'b1;
    tick();
    hd = m_data; hc = m_ch;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (bus.req_ready !== '0) begin fails++; $display("FAIL bp_ready[%0d]: got %b want 0", i, bus.req_ready); end
      tick();
      checks++; if (bus.out_valid !== 1'b1 || bus.out_ch !== ch_idx_t'(hc) || bus.out_data !== hd) begin fails++; $display("FAIL bp_hold[%0d]: got v=%b ch=%0d d=%0d want 1/%0d/%0d", i, bus.out_valid, bus.out_ch, bus.out_data, hc, hd); end
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (m_acc < 0 || bus.out_valid !== 1'b1 || bus.out_ch !== ch_idx_t'(m_ch) || bus.out_data !== m_data) begin fails++; $display("FAIL bp_release[%0d]: got v=%b ch=%0d d=%0d want 1/%0d/%0d", i, bus.out_valid, bus.out_ch, bus.out_data, m_ch, m_data); end
    end
    bus.req_valid = '0;
    tick();
  endtask
  task automatic test_clear();
    int d[4] = '{4, 8, 12, 16};
    apply_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.req_valid = ch_vec_t'(1); bus.req_data[0] = data_t'(d[i]);
      tick();
    end
    clear = 1'b1; bus.req_data[0] = data_t'(40);
    #1;
    checks++; if (bus.req_ready !== '0) begin fails++; $display("FAIL clear_ready: got %b want 0", bus.req_ready); end
    checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== data_t'(10)) begin fails++; $display("FAIL clear_pending: got v=%b d=%0d want 1/10", bus.out_valid, bus.out_data); end
    tick();
    clear = 1'b0;
    checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL clear_drain: got v=%b want 0", bus.out_valid); end
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_ch !== '0 || bus.out_data !== data_t'(10)) begin fails++; $display("FAIL clear_after: got v=%b ch=%0d d=%0d want 1/0/10", bus.out_valid, bus.out_ch, bus.out_data); end
    bus.req_valid = '0;
  endtask
  task automatic test_reset_mid();
    bus.req_valid = '1; bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0; rst = 1'b1; clear = 1'b1;
    #1;
    checks++; if (bus.req_ready !== '0) begin fails++; $display("FAIL rstmid_ready: got %b want 0", bus.req_ready); end
    tick();
    rst = 1'b0; clear = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || bus.out_ch !== '0 || bus.out_data !== '0) begin fails++; $display("FAIL rstmid_out: got v=%b ch=%0d d=%0d want 0/0/0", bus.out_valid, bus.out_ch, bus.out_data); end
    bus.req_valid = ch_vec_t'(1); bus.req_data[0] = data_t'(8); bus.out_ready = 1'b1;
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_ch !== '0 || bus.out_data !== data_t'(2)) begin fails++; $display("FAIL rstmid_hist: got v=%b ch=%0d d=%0d want 1/0/2", bus.out_valid, bus.out_ch, bus.out_data); end
    bus.req_valid = '0;
  endtask
  task automatic test_random();
    bus.req_valid = '0;
    for (int n = 0; n < 1000; n++) begin
      for (int c = 0; c < NUM_CH; c++)
        if (!bus.req_valid[c] || m_acc == c) begin
          bus.req_valid[c] = 1'($urandom % 2);
          bus.req_data[c] = data_t'($urandom % 32'hFFFF);
        end
      bus.out_ready = ($urandom % 4) != 0;
      #1;
      checks++; if (bus.req_ready !== exp_ready()) begin fails++; $display("FAIL rnd_ready[%0d]: got %b want %b", n, bus.req_ready, exp_ready()); end
      checks++; if (bus.out_valid !== m_valid) begin fails++; $display("FAIL rnd_valid[%0d]: got %b want %b", n, bus.out_valid, m_valid); end
      if (m_valid) begin
        checks++; if (bus.out_ch !== ch_idx_t'(m_ch) || bus.out_data !== m_data) begin fails++; $display("FAIL rnd_out[%0d]: got ch=%0d d=%0d want %0d/%0d", n, bus.out_ch, bus.out_data, m_ch, m_data); end
      end
      tick();
    end
    bus.req_valid = '0;
  endtask
  initial begin
    rst = 1'b1; clear = 1'b0; bus.req_valid = '0; bus.req_data = '0; bus.out_ready = 1'b0;
    m_valid = 1'b0; m_ch = 0; m_acc = -1; m_data = '0;
`ifdef BOX_FILTER_SCHED_RR_EN
    m_ptr = NUM_CH - 1;
`endif
    zero_windows();
    test_reset();
    test_single();
    test_isolation();
    test_arbitration();
    test_backpressure();
    test_clear();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/box_filter_sched.md
# box_filter_sched

Multi-channel scheduler that shares one box-filter datapath (running sum and divide by FILTER_SIZE) among NUM_CH independent sample streams. It arbitrates per-cycle among the requesting channels and keeps a separate history and running sum for each channel, so every stream sees exactly the response of a dedicated box filter. The filtered result is tagged with its channel and returned through a single valid/ready output port. The block sits between the per-channel sample producers and the downstream consumer.

## Interface
- NUM_CH, 4: number of requesting channels, at least 2.
- FILTER_SIZE, 4: window length per channel; a power of two, at least 2.
- DATA_WIDTH, 32: sample and result width.
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset; synchronous and active-high.
- clear  input  1  synchronous flush of all channel histories.
- req_valid  input  NUM_CH  per-channel sample valid.
- req_data  input  NUM_CH x DATA_WIDTH  per-channel sample, unsigned.
- req_ready  output  NUM_CH  per-channel accept; one-hot or zero.
- out_valid  output  1  result valid.
- out_ch  output  $clog2(NUM_CH)  channel index of the result.
- out_data  output  DATA_WIDTH  filtered result.
- out_ready  input  1  consumer accepts the result.

## Operation
- Per-channel state:
  - a FILTER_SIZE-entry history ring;
  - a write pointer of log2(FILTER_SIZE) bits, which wraps naturally;
  - a running sum of DATA_WIDTH+log2(FILTER_SIZE) bits, which cannot overflow.
- can_accept = !out_valid || out_ready.
- grant = arbiter pick among req_valid.
- req_ready[grant] = can_accept && !clear && !rst. All other ready bits are 0.
- Accept on channel c (req_valid[c] && req_ready[c]):
  - sum_c <= sum_c - hist_c[wp_c] + req_data[c];
  - hist_c[wp_c] <= req_data[c];
  - wp_c <= wp_c + 1;
  - the output register loads out_ch = c and out_data = (new sum_c) >> log2(FILTER_SIZE), truncating, with the upper bits dropped;
  - out_valid <= 1.
- The window includes zero-initialised history. The first FILTER_SIZE results of a channel therefore average in zeros. There is no warm-up suppression.
- When out_valid && out_ready and there is no new accept, out_valid <= 0. out_ch and out_data hold their last values.
- Producers must not make req_valid depend on req_ready. req_data must stay stable while valid and not yet accepted.
- clear:
  - zeroes all histories, sums and write pointers;
  - blocks accepts in that cycle;
  - leaves the output register and arbiter pointer untouched. A pending result is still delivered.
- Arbiter pointer: holds the last granted channel, and updates only on accept.

## Timing
- Reset values:
  - out_valid = 0, out_ch = 0, out_data = 0;
  - all histories, sums and pointers = 0;
  - the arbiter pointer = NUM_CH-1, so channel 0 has first priority;
  - req_ready = 0 while rst is high.
- Latency: a sample accepted in cycle N gives out_valid with its result in cycle N+1.
- Throughput: one sample per cycle when out_ready is held high.
- Back-pressure:
  - out_valid=1 && out_ready=0 forces all req_ready bits low;
  - out_ch and out_data are held stable until the handshake completes.
- Simultaneous output handshake and new accept in the same cycle: the register reloads with the new result, and out_valid stays 1.
- rst asserted mid-operation: the pending result is discarded and all state returns to its reset values on the next edge.
- rst and clear together: rst dominates, with the same end state.

## Configuration
- BOX_FILTER_SCHED_RR_EN defined: round-robin arbitration.
  - The search starts at pointer+1 modulo NUM_CH.
  - A continuously requesting channel waits at most NUM_CH-1 accepts.
- Not defined: fixed priority, where the lowest valid index wins.
  - The pointer register is removed.
  - Starvation of higher indices is permitted.

## Structure
- Shared package box_filter_pkg holds:
  - localparam LOG2_FS = $clog2(FILTER_SIZE);
  - typedefs data_t (DATA_WIDTH), sum_t (DATA_WIDTH+LOG2_FS), ch_idx_t ($clog2(NUM_CH)) and wp_t (LOG2_FS).
- One sub-module, box_filter_sched_arb, is natural. It is purely combinational and contains:
  - grant selection, with a one-hot and index output;
  - the macro-dependent round-robin/fixed-priority logic.
- Histories, sums and the output register stay in the top module.

## Test plan
- Single channel: NUM_CH=4, FILTER_SIZE=4. Push 4, 8, 12, 16, 20 on channel 0 with out_ready=1. Expect out_ch=0 and out_data 1, 3, 6, 10, 14, one cycle after each accept.
- Isolation: interleave channel 1 with 100, 100, 100, 100 and channel 2 with 8, 8. Expect channel 1 results 25, 50, 75, 100 and channel 2 results 2, 4. Channel 0 history is unaffected.
- Arbitration (RR_EN): all four channels valid continuously. Expect grant order 0, 1, 2, 3, 0, … Without the macro, expect grants 0, 0, 0, …
- Back-pressure: hold out_ready=0 for 5 cycles with channels valid. Expect:
  - req_ready stays 0;
  - out_data and out_ch stay stable;
  - after release, one result per cycle with no loss.
- Clear: after channel 0 holds 4, 8, 12, 16, assert clear for one cycle, then push 40. Expect:
  - no accept during the clear cycle;
  - the pending result is still delivered;
  - the next result is 10.
- Random: random req_valid, req_data (mod 16'hFFFF) and out_ready over 1000 cycles. Check each channel against the software BoxFilter model with FILTER_SIZE entries, checking every (out_ch, out_data).
